// File: rtl/cnt_gen_nms_prog.sv
// Programmable N-ms tick generator driving a loadable modulo up/down counter.
// A 1 ms prescaler steps a period divider whose length is re-latched only at period end.
module cnt_gen_nms_prog #(
    parameter int CLK_PER_MS = 50000,
    parameter int PW         = 10,
    parameter int CW         = 10
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          ce,
    input  logic [PW-1:0] period,
    input  logic          up,
    input  logic          load,
    input  logic [CW-1:0] din,
    input  logic [CW-1:0] modulus,
    output logic [CW-1:0] q,
    output logic          tick,
    output logic          tc,
    output logic          ceo
);
    localparam int PRE_W = $clog2(CLK_PER_MS);
    // Wide enough for both the 1000 ms default and any programmed period.
    localparam int PC_W  = (PW + 1 > 10) ? PW + 1 : 10;
    localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(CLK_PER_MS - 1);
    localparam logic [PC_W-1:0]  ONE_S_LAST = PC_W'(999);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [PC_W-1:0]  len_last;
    logic [PW-1:0]    per_q, per_d;
    logic             tick_q, tick_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ceo_q, ceo_d;
    logic             ms_p;
    logic             per_end;

    assign ms_p     = ce && (pre_q == PRE_LAST);
    assign len_last = (per_q == '0) ? ONE_S_LAST : (PC_W'(per_q) - PC_W'(1));
    assign per_end  = ms_p && (pc_q == len_last);

    always_comb begin
        pre_d  = pre_q;
        pc_d   = pc_q;
        per_d  = per_q;
        tick_d = 1'b0;
        if (ms_p) begin
            pre_d = '0;
        end else if (ce) begin
            pre_d = pre_q + PRE_W'(1);
        end
        if (per_end) begin
            pc_d   = '0;
            tick_d = 1'b1;
            per_d  = period;
        end else if (ms_p) begin
            pc_d = pc_q + PC_W'(1);
        end
    end

    // A load wins over a coincident tick; out-of-range values are pulled back to modulus.
    always_comb begin
        cnt_d = cnt_q;
        ceo_d = 1'b0;
        if (load) begin
            cnt_d = (din > modulus) ? modulus : din;
        end else if (tick_q) begin
            if (up) begin
                if (cnt_q >= modulus) begin
                    cnt_d = '0;
                    ceo_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end else begin
                if (cnt_q == '0) begin
                    cnt_d = modulus;
                    ceo_d = 1'b1;
                end else if (cnt_q > modulus) begin
                    cnt_d = modulus;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            pre_q  <= '0;
            pc_q   <= '0;
            per_q  <= period;
            tick_q <= 1'b0;
            cnt_q  <= '0;
            ceo_q  <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            pc_q   <= pc_d;
            per_q  <= per_d;
            tick_q <= tick_d;
            cnt_q  <= cnt_d;
            ceo_q  <= ceo_d;
        end
    end

    assign q    = cnt_q;
    assign tick = tick_q;
    assign ceo  = ceo_q;
    assign tc   = up ? (cnt_q == modulus) : (cnt_q == '0);

endmodule

// File: tb/tb_cnt_gen_nms_prog.sv
// Bench for cnt_gen_nms_prog: elapsed-cycle tick model plus modulo counter model,
// compared every cycle, with directed scenarios pinned by literal expectations.
module tb_cnt_gen_nms_prog;
    localparam int CPM = 4;
    localparam int PW  = 10;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          clr, ce, up, load;
    logic [PW-1:0] period;
    logic [CW-1:0] din, modulus;
    logic [CW-1:0] q;
    logic          tick, tc, ceo;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit mdl_on = 1'b0;

    // Model state: enabled cycles elapsed in the current period, latched period, counter.
    int m_en, m_per, m_q, m_len;
    bit m_tick, m_ceo, m_t;

    cnt_gen_nms_prog #(.CLK_PER_MS(CPM), .PW(PW), .CW(CW)) dut (
        .clk(clk), .clr(clr), .ce(ce), .period(period), .up(up), .load(load),
        .din(din), .modulus(modulus), .q(q), .tick(tick), .tc(tc), .ceo(ceo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!clr) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (!clr) begin
            m_en = 0; m_per = period; m_tick = 0; m_q = 0; m_ceo = 0;
        end else begin
            m_len = ((m_per == 0) ? 1000 : m_per) * CPM;
            m_t = 0;
            if (ce) begin
                if (m_en + 1 == m_len) begin
                    m_t = 1; m_en = 0; m_per = period;
                end else begin
                    m_en++;
                end
            end
            m_ceo = 0;
            if (load) begin
                m_q = (din < modulus) ? din : modulus;
            end else if (m_tick && up) begin
                if (m_q >= modulus) begin m_q = 0; m_ceo = 1; end
                else m_q = m_q + 1;
            end else if (m_tick && !up) begin
                if (m_q == 0) begin m_q = modulus; m_ceo = 1; end
                else if (m_q > modulus) m_q = modulus;
                else m_q = m_q - 1;
            end
            m_tick = m_t;
        end
    end

    always @(negedge clk) begin
        if (mdl_on) begin
            check("q", q, m_q);
            check("tick", tick, m_tick);
            check("ceo", ceo, m_ceo);
            check("tc", tc, up ? (m_q == modulus) : (m_q == 0));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int target);
        int n = 0;
        while (cyc != target && n < 20000) begin
            step();
            n++;
        end
        if (cyc != target) begin
            checks++;
            errors++;
            $display("FAIL wait_cyc timeout: got cycle %0d expected %0d", cyc, target);
        end
    endtask

    task automatic do_reset();
        clr = 1'b0;
        step();
        clr = 1'b1;
    endtask

    initial begin
        clr = 1'b0; ce = 1'b1; period = 10'd3; up = 1'b1; load = 1'b0;
        din = '0; modulus = 4'd9;
        step();
        mdl_on = 1'b1;
        step();
        check("rst_q", q, 0);
        check("rst_tick", tick, 0);
        check("rst_ceo", ceo, 0);

        // Up count, period 3 ms: ticks every 12 cycles, wrap after the 10th.
        clr = 1'b1;
        wait_cyc(12);  check("a_tick12", tick, 1); check("a_q12", q, 0);
        wait_cyc(13);  check("a_q13", q, 1);       check("a_tick13", tick, 0);
        wait_cyc(110); check("a_q110", q, 9);      check("a_tc110", tc, 1);
        wait_cyc(121); check("a_wrap_q", q, 0);    check("a_wrap_ceo", ceo, 1);
        wait_cyc(122); check("a_ceo_once", ceo, 0);

        // Down count from 0 with modulus 5.
        up = 1'b0; modulus = 4'd5;
        do_reset();
        wait_cyc(13); check("b_q13", q, 5); check("b_ceo13", ceo, 1);
        wait_cyc(25); check("b_q25", q, 4); check("b_ceo25", ceo, 0);
        wait_cyc(73); check("b_q73", q, 0); check("b_ceo73", ceo, 0); check("b_tc73", tc, 1);

        // 1 s mode, period changed mid-period takes effect only afterwards.
        up = 1'b1; modulus = 4'd9; period = 10'd0;
        do_reset();
        wait_cyc(100);  period = 10'd2;
        wait_cyc(3999); check("c_tick3999", tick, 0);
        wait_cyc(4000); check("c_tick4000", tick, 1);
        wait_cyc(4001); check("c_q4001", q, 1);
        wait_cyc(4004); check("c_tick4004", tick, 0);
        wait_cyc(4008); check("c_tick4008", tick, 1);

        // Load in the tick cycle, then a clamped load.
        period = 10'd3;
        do_reset();
        wait_cyc(12); check("d_tick12", tick, 1); load = 1'b1; din = 4'd7;
        wait_cyc(13); load = 1'b0; check("d_q13", q, 7); check("d_ceo13", ceo, 0);
        wait_cyc(14); load = 1'b1; din = 4'd12;
        wait_cyc(15); load = 1'b0; check("d_q15", q, 9);

        // Five disabled cycles delay the tick by five.
        wait_cyc(16); ce = 1'b0;
        wait_cyc(21); ce = 1'b1;
        wait_cyc(24); check("e_tick24", tick, 0);
        wait_cyc(29); check("e_tick29", tick, 1);
        wait_cyc(30); check("e_q30", q, 0); check("e_ceo30", ceo, 1);
        wait_cyc(31); load = 1'b1; din = 4'd7;
        wait_cyc(32); load = 1'b0; check("e_q32", q, 7);
        wait_cyc(33); modulus = 4'd3; check("e_tc33", tc, 0);
        wait_cyc(42); check("e_q42", q, 0); check("e_ceo42", ceo, 1);

        // Reset one cycle before a due tick (tick due in cycle 53).
        modulus = 4'd9;
        wait_cyc(52);
        do_reset();
        check("f_cyc0", cyc, 0);
        check("f_q0", q, 0); check("f_tick0", tick, 0); check("f_ceo0", ceo, 0);
        wait_cyc(11); check("f_tick11", tick, 0);
        wait_cyc(12); check("f_tick12", tick, 1);
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cnt_gen_nms_prog.md
# cnt_gen_nms_prog

Programmable-period tick generator fused with a modulo up/down counter. It is the parametrised successor to the fixed N-ms/1-s generator plus 10-bit counter pair. A millisecond prescaler feeds a runtime-selectable N-ms period divider, and that divider steps a loadable counter of configurable width and modulus. Outputs `q` and `ceo` feed the DISPLAY path and downstream cascaded counters.

## Interface
- `CLK_PER_MS`, 50000: clk cycles per millisecond (50 MHz board); ≥2.
- `PW`, 10: width of `period`.
- `CW`, 10: counter width.

- `clk`  in  1  system clock, all state on rising edge.
- `clr`  in  1  synchronous reset, active-low: state resets on a rising edge where `clr`=0.
- `ce`  in  1  enable for prescaler and period divider.
- `period`  in  PW  tick period in ms; 0 selects 1000 ms (1 s mode).
- `up`  in  1  1 = count up, 0 = count down.
- `load`  in  1  synchronous load of `din`.
- `din`  in  CW  load value.
- `modulus`  in  CW  counter range 0..`modulus` inclusive.
- `q`  out  CW  counter value.
- `tick`  out  1  registered one-cycle pulse, once per period.
- `tc`  out  1  combinational terminal count: (`up` & `q`==`modulus`) | (!`up` & `q`==0).
- `ceo`  out  1  registered one-cycle carry/borrow pulse on wrap.

## Operation
- Reset (`clr`=0): pre=0, pc=0, per_r←`period`, q=0, tick=0, ceo=0. `clr` has priority over everything.
- Prescaler pre (0..CLK_PER_MS-1): increments when `ce`=1. Internal ms_p = `ce` & (pre==CLK_PER_MS-1); on ms_p, pre wraps to 0.
- Period divider pc: effective length L = (per_r==0) ? 1000 : per_r.
  - On ms_p with pc≠L-1: pc←pc+1.
  - On ms_p with pc==L-1: pc←0, tick←1, per_r←`period`. New period applies only from the next period; a mid-period change of `period` never truncates the current one.
  - tick is cleared on every other cycle.
- `ce`=0 freezes pre and pc. An already-asserted tick is still consumed.
- Counter, evaluated at each edge in priority order:
  1. `load`: q←min(`din`,`modulus`). A coincident tick is discarded; ceo←0.
  2. tick & `up`:
     - q≥`modulus`: q←0, ceo←1.
     - otherwise: q←q+1, ceo←0.
  3. tick & !`up`:
     - q==0: q←`modulus`, ceo←1.
     - q>`modulus`: q←`modulus`, ceo←0.
     - otherwise: q←q-1, ceo←0.
  4. Else: q holds, ceo←0.
- `modulus`=0: q stays 0 and ceo pulses on every tick.
- Arithmetic is unsigned CW-bit with no overflow beyond the modulus rules.
- pc is PW+1 bits wide minimum so that 1000 fits when PW<10. Internal widths are sized as ceil(log2) of each range.

## Timing
- Cycle 0 is the first cycle with `clr`=1, and `ce`=1 continuously from then.
  - ms_p is high during cycles k·CLK_PER_MS-1.
  - tick is high during cycle L·CLK_PER_MS.
- Tick spacing is exactly L·CLK_PER_MS cycles.
- q changes at the edge ending the tick cycle: 1-cycle latency tick→q.
- ceo is high in the same cycle that q shows its wrapped value.
- `load` latency: 1 cycle. `tc` has 0 latency relative to q, `up`, and `modulus`.
- Reset mid-operation: all outputs return to reset values at the next edge. A pending tick is lost and the period restarts from 0 on release.

## Test plan
(CLK_PER_MS=4, CW=4.)
- `period`=3, `up`=1, `modulus`=9 → tick high cycles 12, 24, 36…; q=1 from cycle 13; after the 10th tick q=0 with ceo=1 for exactly one cycle; tc=1 while q=9.
- `period`=3, `up`=0, `modulus`=5, start q=0 → first tick yields q=5, ceo=1; subsequent ticks give q=4,3,2,1,0 with no ceo.
- `period`=0 → ticks every 4000 cycles. Change `period` 0→2 mid-period → current period still completes at 4000; the next tick follows 8 cycles later.
- `load`=1 with `din`=7 in the tick cycle, `modulus`=9 → q=7 next cycle, ceo=0, no increment. `din`=12 → q=9.
- `ce`=0 for 5 cycles mid-period → next tick delayed by exactly 5 cycles. `modulus` lowered to 3 while q=7, up → next tick q=0, ceo=1.
- Drive `clr`=0 one cycle before a due tick → no tick; q=0, ceo=0. The first tick after release occurs at cycle L·4.
